// File: rtl/uart_axis_transceiver.sv
// uart_axis_transceiver: full-duplex 8N1 UART bridging AXI-Stream bytes to TX/RX serial lines
module uart_axis_transceiver #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int N_BITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] axis_tdata,
  input  logic              axis_tvalid,
  output logic              axis_tready,
  output logic              tx_data,
  input  logic              rx_data,
  output logic [N_BITS-1:0] uart_rx_tdata,
  output logic              uart_rx_tvalid,
  input  logic              uart_rx_tready,
  output logic              rx_frame_err,
  output logic              rx_overrun
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [3:0] NLAST = 4'(N_BITS - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

  tx_state_t tx_st, tx_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [3:0] tx_bit, tx_bit_nx;
  logic [N_BITS-1:0] tx_sh, tx_sh_nx;
  logic tx_q_nx, tx_end;

  assign tx_end = tx_cnt == LAST;
  assign axis_tready = tx_st == T_IDLE;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_data <= 1'b1;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_bit <= tx_bit_nx;
      tx_sh <= tx_sh_nx;
      tx_data <= tx_q_nx;
    end

  always_comb begin
    tx_nx = tx_st;
    tx_cnt_nx = tx_end ? '0 : tx_cnt + 1'b1;
    tx_bit_nx = tx_bit;
    tx_sh_nx = tx_sh;
    case (tx_st)
      T_IDLE: begin
        tx_cnt_nx = '0;
        if (axis_tvalid) begin
          tx_nx = T_START;
          tx_sh_nx = axis_tdata;
          tx_bit_nx = '0;
        end
      end
      T_START: if (tx_end) tx_nx = T_DATA;
      T_DATA: if (tx_end) begin
        tx_sh_nx = tx_sh >> 1;
        tx_bit_nx = tx_bit + 1'b1;
        if (tx_bit == NLAST) tx_nx = T_STOP;
      end
      T_STOP: if (tx_end) tx_nx = T_IDLE;
      default: tx_nx = T_IDLE;
    endcase
    // line is registered from next state so the pin never glitches
    tx_q_nx = tx_nx == T_START ? 1'b0 : tx_nx == T_DATA ? tx_sh_nx[0] : 1'b1;
  end

  rx_state_t rx_st, rx_nx;
  logic rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [3:0] rx_bit, rx_bit_nx;
  logic [N_BITS-1:0] rx_sh, rx_sh_nx;
  logic [N_BITS:0] rx_shift;
  logic rx_load, rx_ferr, rx_end;

  assign rx_end = rx_cnt == LAST;
  assign rx_shift = {rx_s2, rx_sh};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      uart_rx_tdata <= '0;
      uart_rx_tvalid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1 <= rx_data;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_st <= rx_nx;
      rx_cnt <= rx_cnt_nx;
      rx_bit <= rx_bit_nx;
      rx_sh <= rx_sh_nx;
      rx_frame_err <= rx_ferr;
      rx_overrun <= rx_load & uart_rx_tvalid & ~uart_rx_tready;
      if (rx_load) begin
        uart_rx_tdata <= rx_sh;
        uart_rx_tvalid <= 1'b1;
      end else if (uart_rx_tready) uart_rx_tvalid <= 1'b0;
    end

  always_comb begin
    rx_nx = rx_st;
    rx_cnt_nx = rx_cnt + 1'b1;
    rx_bit_nx = rx_bit;
    rx_sh_nx = rx_sh;
    rx_load = 1'b0;
    rx_ferr = 1'b0;
    case (rx_st)
      R_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev & ~rx_s2) rx_nx = R_START;
      end
      R_START: if (rx_cnt == HALF) begin
        rx_cnt_nx = '0;
        rx_bit_nx = '0;
        rx_nx = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_end) begin
        rx_cnt_nx = '0;
        rx_sh_nx = rx_shift[N_BITS:1];
        rx_bit_nx = rx_bit + 1'b1;
        if (rx_bit == NLAST) rx_nx = R_STOP;
      end
      R_STOP: if (rx_end) begin
        rx_cnt_nx = '0;
        rx_load = rx_s2;
        rx_ferr = ~rx_s2;
        rx_nx = rx_s2 ? R_IDLE : R_BREAK;
      end
      // a held-low line after a bad stop bit must not look like a new start
      R_BREAK: begin
        rx_cnt_nx = '0;
        if (rx_s2) rx_nx = R_IDLE;
      end
      default: rx_nx = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_axis_transceiver.sv
// tb_uart_axis_transceiver: directed-vector bench for the UART transceiver at DIV=16
module tb_uart_axis_transceiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] axis_tdata = 8'h00;
  logic axis_tvalid = 1'b0;
  logic axis_tready, tx_data;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic rx_line;
  logic [7:0] uart_rx_tdata;
  logic uart_rx_tvalid;
  logic uart_rx_tready = 1'b1;
  logic rx_frame_err, rx_overrun;

  assign rx_line = loop ? tx_data : rx_drv;

  uart_axis_transceiver #(.CLK_FREQ(160), .BAUD_RATE(10), .N_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .tx_data(tx_data), .rx_data(rx_line),
    .uart_rx_tdata(uart_rx_tdata), .uart_rx_tvalid(uart_rx_tvalid), .uart_rx_tready(uart_rx_tready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, ferr_cnt = 0, ovr_cnt = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (uart_rx_tvalid && uart_rx_tready) rx_q.push_back(uart_rx_tdata);
    if (rx_frame_err) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic [9:0] line);
    @(negedge clk);
    axis_tdata = b;
    axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    axis_tvalid = 1'b0;
    chk("tready_fall", 32'(axis_tready), 32'd0);
    for (int c = 0; c < 160; c++) begin
      if (c % 16 == 0 || c % 16 == 15) chk($sformatf("tx_bit%0d_c%0d", c / 16, c), 32'(tx_data), 32'(line[c/16]));
      if (c == 159) chk("tready_busy_end", 32'(axis_tready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("tready_return", 32'(axis_tready), 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = i == 0 ? 1'b0 : i == 9 ? stop : b[i-1];
      repeat (15) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic [9:0] line;
  } txv_t;

  txv_t tv[4];
  int qb, fb, ob;

  initial begin
    tv[0] = '{8'hA5, 10'b1101001010};
    tv[1] = '{8'h00, 10'b1000000000};
    tv[2] = '{8'hFF, 10'b1111111110};
    tv[3] = '{8'h3C, 10'b1001111000};
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd1);
    chk("rst_tready", 32'(axis_tready), 32'd1);
    chk("rst_rx_tvalid", 32'(uart_rx_tvalid), 32'd0);
    chk("rst_rx_tdata", 32'(uart_rx_tdata), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    loop = 1'b1;
    qb = rx_q.size(); fb = ferr_cnt; ob = ovr_cnt;
    for (int i = 0; i < 4; i++) tx_frame(tv[i].b, tv[i].line);
    repeat (40) @(negedge clk);
    chk("loop_count", 32'(rx_q.size() - qb), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("loop_byte%0d", i), 32'(rx_q[qb+i]), 32'(tv[i].b));
    chk("loop_ferr", 32'(ferr_cnt - fb), 32'd0);
    chk("loop_ovr", 32'(ovr_cnt - ob), 32'd0);

    loop = 1'b0;
    repeat (20) @(negedge clk);
    qb = rx_q.size(); fb = ferr_cnt;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_byte", 32'(rx_q.size() - qb), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - fb), 32'd0);
    chk("glitch_tvalid", 32'(uart_rx_tvalid), 32'd0);
    rx_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_glitch_count", 32'(rx_q.size() - qb), 32'd1);
    chk("after_glitch_byte", 32'(rx_q[qb]), 32'h5A);

    qb = rx_q.size(); fb = ferr_cnt;
    rx_frame(8'h81, 1'b0);
    repeat (48) @(negedge clk);
    chk("frame_err_once", 32'(ferr_cnt - fb), 32'd1);
    chk("frame_no_byte", 32'(rx_q.size() - qb), 32'd0);
    chk("frame_tvalid", 32'(uart_rx_tvalid), 32'd0);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("break_no_retrigger", 32'(ferr_cnt - fb), 32'd1);
    rx_frame(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    chk("rearm_count", 32'(rx_q.size() - qb), 32'd1);
    chk("rearm_byte", 32'(rx_q[qb]), 32'hC3);

    @(negedge clk);
    uart_rx_tready = 1'b0;
    qb = rx_q.size(); ob = ovr_cnt;
    rx_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    chk("bp_tvalid1", 32'(uart_rx_tvalid), 32'd1);
    chk("bp_tdata1", 32'(uart_rx_tdata), 32'h11);
    chk("bp_ovr0", 32'(ovr_cnt - ob), 32'd0);
    rx_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    chk("bp_tvalid2", 32'(uart_rx_tvalid), 32'd1);
    chk("bp_tdata2", 32'(uart_rx_tdata), 32'h22);
    chk("bp_ovr1", 32'(ovr_cnt - ob), 32'd1);
    chk("bp_no_handshake", 32'(rx_q.size() - qb), 32'd0);
    @(negedge clk);
    uart_rx_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_tvalid_clear", 32'(uart_rx_tvalid), 32'd0);
    chk("bp_drain_count", 32'(rx_q.size() - qb), 32'd1);
    chk("bp_drain_byte", 32'(rx_q[qb]), 32'h22);

    @(negedge clk);
    axis_tdata = 8'hF0;
    axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    axis_tvalid = 1'b0;
    repeat (72) @(negedge clk);
    chk("txrst_mid_bit3", 32'(tx_data), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("txrst_tx_data", 32'(tx_data), 32'd1);
    chk("txrst_tready", 32'(axis_tready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    qb = rx_q.size(); fb = ferr_cnt;
    rx_drv = 1'b0;
    repeat (5 * 16 + 8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rxrst_tvalid", 32'(uart_rx_tvalid), 32'd0);
    chk("rxrst_tdata", 32'(uart_rx_tdata), 32'd0);
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rxrst_no_byte", 32'(rx_q.size() - qb), 32'd0);
    chk("rxrst_no_ferr", 32'(ferr_cnt - fb), 32'd0);

    loop = 1'b1;
    tx_frame(8'h7E, 10'b1011111100);
    repeat (40) @(negedge clk);
    chk("fresh_count", 32'(rx_q.size() - qb), 32'd1);
    chk("fresh_byte", 32'(rx_q[qb]), 32'h7E);
    chk("fresh_ferr", 32'(ferr_cnt - fb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_axis_transceiver.md
Name: uart_axis_transceiver

Overview:
- Full-duplex 8N1 UART core: an AXI-Stream-style byte input is serialised onto a TX line, and a serial RX line is deserialised onto an AXI-Stream-style byte output.
- Sits between board pins (GPS module, USB bridge) and byte-stream logic; RX output can drive TX input directly for a pass-through echo.
- TX and RX paths are independent and share only clock and reset.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD_RATE clocks, integer-truncated (2604 at defaults), DIV >= 4 required.
- N_BITS, 8, data bits per frame (1..8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- axis_tdata  in  N_BITS  byte to transmit.
- axis_tvalid  in  1  axis_tdata valid.
- axis_tready  out  1  transmitter idle, can accept a byte.
- tx_data  out  1  serial TX line, idle high.
- rx_data  in  1  serial RX line, asynchronous to clk.
- uart_rx_tdata  out  N_BITS  last received byte.
- uart_rx_tvalid  out  1  uart_rx_tdata holds an unconsumed byte.
- uart_rx_tready  in  1  consumer accepts byte.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  out  1  one-cycle pulse: new byte overwrote an unconsumed byte.

Behaviour:
- Reset (rst=0, async): tx_data=1, axis_tready=1, uart_rx_tvalid=0, uart_rx_tdata=0, both pulses 0, both FSMs IDLE, all counters 0.
- Frame format: 1 start bit (0), N_BITS data bits LSB first, 1 stop bit (1), no parity; every bit lasts exactly DIV clocks.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: axis_tready=1, tx_data=1.
  - Handshake on axis_tvalid & axis_tready at edge E: byte latched, axis_tready=0 from E.
  - tx_data=0 from E for DIV clocks, then data bits, then stop bit.
  - Frame occupies (N_BITS+2)*DIV clocks (10*DIV at defaults); axis_tready returns to 1 in the cycle after the stop bit's last clock.
  - axis_tdata/axis_tvalid ignored while busy.
  - Back-to-back valid bytes produce frames with no idle gap beyond that one cycle.
- RX:
  - rx_data passes a 2-flop synchroniser (reset value 1); all RX timing refers to the synchronised signal.
  - IDLE: falling edge (1->0) enters START.
  - START: after DIV/2 clocks resample; if 1, false start, return to IDLE with no output; if 0, enter DATA.
  - DATA: sample every DIV clocks (mid-bit), shift in LSB first, N_BITS samples.
  - STOP: sample DIV clocks later.
    - Stop=1: uart_rx_tdata <= shifted byte and uart_rx_tvalid <= 1 on the next edge. If uart_rx_tvalid was already 1 without handshake in that cycle, also pulse rx_overrun (new byte wins).
    - Stop=0: rx_frame_err pulses, data discarded, tvalid unchanged; the FSM then waits for the line to return to 1 before re-arming IDLE (a break does not retrigger).
  - After the stop sample the FSM returns to IDLE immediately; the next start edge may follow within the same bit time.
- RX output handshake: uart_rx_tvalid & uart_rx_tready at an edge clears tvalid; uart_rx_tdata holds its value until the next good byte. Simultaneous handshake and new-byte load: load wins, tvalid stays 1, no overrun.
- uart_rx_tready is ignored while uart_rx_tvalid=0; RX never stalls the line.
- Reset asserted mid-frame in either path aborts immediately to reset values; a partially received byte is never output.
- Counters wide enough for DIV; no combinational path from inputs to outputs except axis_tready, which is decoded from TX state only.

Test Plan:
- Use CLK_FREQ=160, BAUD_RATE=10 (DIV=16) unless stated. TX byte: axis_tdata=0xA5, tvalid pulsed one cycle -> axis_tready falls at the same edge; tx_data reads 0,1,0,1,0,0,1,0,1,1 across 16-clock bits; tready back to 1 after 160 clocks.
- Loopback (tx_data to rx_data), send 0x00, 0xFF, 0x3C back-to-back with uart_rx_tready=1 -> uart_rx_tvalid pulses three times with matching data, no error pulses.
- Glitch: drive rx_data low for 5 clocks, then high -> no tvalid, no rx_frame_err; a following valid 0x5A frame is received correctly.
- Framing: drive a frame of 0x81 with stop bit 0 -> rx_frame_err pulses once, tvalid stays 0; no new frame starts until the line returns high.
- Backpressure: hold uart_rx_tready=0, receive 0x11 then 0x22 -> tvalid held, rx_overrun pulses once, tdata=0x22; raising tready then clears tvalid.
- Reset mid-frame: assert rst=0 during TX data bit 3 and during RX bit 4 -> tx_data=1 and axis_tready=1 immediately, no RX output; after release, a fresh 0x7E transfers correctly.
